// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : Central stall/flush sequencer for the 5-stage pipeline. Each
//             cycle it decides whether IF/ID, ID/EX and EX/MEM hold or take a
//             bubble. It considers three sources: load-use hazards, taken
//             branches or jumps resolved in EX, and the data-memory
//             req/ready handshake in MEM. It also aborts a memory access
//             that times out.
//  Option   : PIPE_HAZARD_PERF_EN - when defined, adds 32-bit stall-cycle
//             and branch-flush counters. When undefined, the perf ports are
//             tied to 0 and no counter flops exist.
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int REGISTER_ADDR_WIDTH = 5,
    parameter int MEM_TIMEOUT         = 16,
    parameter int WAIT_CNT_WIDTH      = 8
) (
    input  logic                           cpu_clk,
    input  logic                           cpu_rst_n,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rs1_ID_i,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rs2_ID_i,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rd_EX_i,
    input  logic                           reg_write_EX_i,
    input  logic [1:0]                     result_sel_EX_i,
    input  logic                           pc_src_EX_i,
    input  logic                           mem_read_MEM_i,
    input  logic                           mem_write_MEM_i,
    input  logic                           dmem_ready_i,
    output logic                           dmem_req_o,
    output logic                           stall_IF_o,
    output logic                           stall_ID_o,
    output logic                           flush_ID_o,
    output logic                           flush_EX_o,
    output logic                           hold_EX_MEM_o,
    output logic                           flush_MEM_WB_o,
    output logic                           mem_err_o,
    output logic [31:0]                    perf_stall_cnt_o,
    output logic [31:0]                    perf_flush_cnt_o
);

    localparam logic [1:0]                c_result_sel_load = 2'b01;
    localparam logic [WAIT_CNT_WIDTH-1:0] c_mem_timeout     = WAIT_CNT_WIDTH'(MEM_TIMEOUT);
    localparam logic [WAIT_CNT_WIDTH-1:0] c_wait_cnt_max    = '1;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [WAIT_CNT_WIDTH-1:0] r_wait_cnt;
    logic [WAIT_CNT_WIDTH-1:0] w_wait_cnt_nxt;
    logic                      r_mem_err;
    logic                      w_mem_err_nxt;

    logic                      w_mem_op;
    logic                      w_load_use;
    logic                      w_timeout_hit;
    logic                      w_mem_stall;
    logic                      w_mem_abort;
    logic                      w_dmem_req;

    // Hazard detection from the current EX/ID/MEM contents.
    always_comb begin
        w_mem_op      = mem_read_MEM_i | mem_write_MEM_i;
        w_load_use    = (result_sel_EX_i == c_result_sel_load) && reg_write_EX_i &&
                        (rd_EX_i != '0) &&
                        ((rd_EX_i == rs1_ID_i) || (rd_EX_i == rs2_ID_i));
        // A zero timeout disables the abort path entirely.
        w_timeout_hit = (MEM_TIMEOUT != 0) && (r_wait_cnt >= c_mem_timeout);
    end

    // State, wait counter and error flag registers.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_mem_err  <= w_mem_err_nxt;
        end
    end

    // Memory handshake sequencing: next state, wait count, stall/abort.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_mem_err_nxt  = r_mem_err;
        w_mem_stall    = 1'b0;
        w_mem_abort    = 1'b0;
        w_dmem_req     = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                w_dmem_req = w_mem_op;
                // A zero-wait access, where ready is already high, never
                // leaves RUN.
                if (w_mem_op && !dmem_ready_i) begin
                    w_mem_stall    = 1'b1;
                    w_state_nxt    = ST_MEM_WAIT;
                    w_wait_cnt_nxt = WAIT_CNT_WIDTH'(1);
                end
            end
            ST_MEM_WAIT: begin
                w_dmem_req = 1'b1;
                if (dmem_ready_i) begin
                    w_state_nxt    = ST_RUN;
                    w_wait_cnt_nxt = '0;
                end else if (w_timeout_hit) begin
                    w_mem_abort    = 1'b1;
                    w_dmem_req     = 1'b0;
                    w_mem_err_nxt  = 1'b1;
                    w_state_nxt    = ST_RUN;
                    w_wait_cnt_nxt = '0;
                end else begin
                    w_mem_stall = 1'b1;
                    // Saturate so that an untimed wait cannot wrap the counter.
                    if (r_wait_cnt != c_wait_cnt_max) begin
                        w_wait_cnt_nxt = r_wait_cnt + WAIT_CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                w_state_nxt    = ST_RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    // Priority-resolved stall/flush outputs, all forced low while in reset.
    always_comb begin
        dmem_req_o     = 1'b0;
        stall_IF_o     = 1'b0;
        stall_ID_o     = 1'b0;
        flush_ID_o     = 1'b0;
        flush_EX_o     = 1'b0;
        hold_EX_MEM_o  = 1'b0;
        flush_MEM_WB_o = 1'b0;
        if (cpu_rst_n) begin
            dmem_req_o = w_dmem_req;
            if (w_mem_stall) begin
                // Freeze the front of the pipe. The EX instruction stays in
                // place, so any hazard it raises is re-evaluated once the
                // memory access releases.
                stall_IF_o     = 1'b1;
                stall_ID_o     = 1'b1;
                hold_EX_MEM_o  = 1'b1;
                flush_MEM_WB_o = 1'b1;
            end else begin
                flush_MEM_WB_o = w_mem_abort;
                if (pc_src_EX_i) begin
                    // The ID instruction is wrong-path, so load-use is moot.
                    flush_ID_o = 1'b1;
                    flush_EX_o = 1'b1;
                end else if (w_load_use) begin
                    stall_IF_o = 1'b1;
                    stall_ID_o = 1'b1;
                    flush_EX_o = 1'b1;
                end
            end
        end
    end

    assign mem_err_o = r_mem_err;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] r_perf_stall_cnt;
    logic [31:0] r_perf_flush_cnt;
    logic        w_branch_flush;

    assign w_branch_flush = pc_src_EX_i && (flush_ID_o || flush_EX_o);

    // Free-running, wrapping performance counters.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_perf_stall_cnt <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            if (stall_IF_o) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
            if (w_branch_flush) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt_o = r_perf_stall_cnt;
    assign perf_flush_cnt_o = r_perf_flush_cnt;
`else
    assign perf_stall_cnt_o = 32'd0;
    assign perf_flush_cnt_o = 32'd0;
`endif

endmodule

`default_nettype wire
